// File: rtl/page_table_walker_if.sv
// Miss / PTE-read / refill signal bundle for the Sv39 page-table walker.
// slave is the walker's view; master is the TLB/memory side.
interface page_table_walker_if;
  logic        miss_valid_i;
  logic        miss_ready_o;
  logic [63:0] miss_va_i;
  logic [43:0] satp_ppn_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [63:0] mem_req_addr_o;
  logic        mem_resp_valid_i;
  logic [63:0] mem_resp_data_i;
  logic        refill_valid_o;
  logic [63:0] refill_va_o;
  logic [63:0] refill_pa_o;
  logic [2:0]  refill_perm_o;
  logic        fault_o;

  modport slave (
    input  miss_valid_i, miss_va_i, satp_ppn_i, mem_req_ready_i,
           mem_resp_valid_i, mem_resp_data_i,
    output miss_ready_o, mem_req_valid_o, mem_req_addr_o,
           refill_valid_o, refill_va_o, refill_pa_o, refill_perm_o, fault_o
  );

  modport master (
    output miss_valid_i, miss_va_i, satp_ppn_i, mem_req_ready_i,
           mem_resp_valid_i, mem_resp_data_i,
    input  miss_ready_o, mem_req_valid_o, mem_req_addr_o,
           refill_valid_o, refill_va_o, refill_pa_o, refill_perm_o, fault_o
  );
endinterface

// File: rtl/page_table_walker.sv
// Sv39 page-table walker: one miss at a time, single-outstanding PTE reads, 4 KiB refill or fault.
// Optional macro PTW_AD_CHECK_EN: a leaf with A=0 faults instead of refilling.
module page_table_walker #(
  parameter int LEVELS  = 3,
  parameter int PA_BITS = 56
) (
  input  logic clk,
  input  logic rst,
  page_table_walker_if.slave bus
);
  localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, REFILL, FAULT} state_t;

  state_t        state;
  logic [63:0]   va_q;
  logic [LW-1:0] lvl_q;

  // PTE address: {base, 12'h0} + VPN[lvl]*8, clipped to PA_BITS.
  function automatic logic [63:0] pte_addr(input logic [43:0] base, input logic [63:0] va,
                                           input logic [LW-1:0] lvl);
    logic [8:0]         vpn;
    logic [PA_BITS-1:0] pa;
    vpn = 9'(va >> (32'd12 + 32'd9 * 32'(lvl)));
    pa  = PA_BITS'({base, 12'h0}) + PA_BITS'({vpn, 3'b000});
    return 64'(pa);
  endfunction

  logic        pte_v, pte_r, pte_w, pte_x, pte_a;
  logic [43:0] pte_ppn, lvl_mask, va_pages, frac_ppn;
  logic        aligned, a_ok;
  logic        unused_pte_bits;

  assign pte_v    = bus.mem_resp_data_i[0];
  assign pte_r    = bus.mem_resp_data_i[1];
  assign pte_w    = bus.mem_resp_data_i[2];
  assign pte_x    = bus.mem_resp_data_i[3];
  assign pte_a    = bus.mem_resp_data_i[6];
  assign pte_ppn  = bus.mem_resp_data_i[53:10];
  assign unused_pte_bits = ^{bus.mem_resp_data_i[63:54], bus.mem_resp_data_i[9:4]};

  // Superpage leaves must have the low 9*level PPN bits clear; refill fractures them
  // to the 4 KiB page the VA points at.
  assign lvl_mask = 44'((64'd1 << (32'd9 * 32'(lvl_q))) - 64'd1);
  assign va_pages = 44'(va_q >> 12);
  assign aligned  = (pte_ppn & lvl_mask) == '0;
  assign frac_ppn = (pte_ppn & ~lvl_mask) | (va_pages & lvl_mask);

`ifdef PTW_AD_CHECK_EN
  assign a_ok = pte_a;
`else
  assign a_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      va_q                <= '0;
      lvl_q               <= '0;
      bus.miss_ready_o    <= 1'b1;
      bus.mem_req_valid_o <= 1'b0;
      bus.mem_req_addr_o  <= '0;
      bus.refill_valid_o  <= 1'b0;
      bus.refill_va_o     <= '0;
      bus.refill_pa_o     <= '0;
      bus.refill_perm_o   <= '0;
      bus.fault_o         <= 1'b0;
    end else begin
      bus.refill_valid_o <= 1'b0;
      bus.fault_o        <= 1'b0;
      case (state)
        IDLE: if (bus.miss_valid_i) begin
          va_q                <= bus.miss_va_i;
          lvl_q               <= LW'(LEVELS - 1);
          bus.miss_ready_o    <= 1'b0;
          bus.mem_req_valid_o <= 1'b1;
          bus.mem_req_addr_o  <= pte_addr(bus.satp_ppn_i, bus.miss_va_i, LW'(LEVELS - 1));
          state               <= REQ;
        end
        REQ: if (bus.mem_req_ready_i) begin
          bus.mem_req_valid_o <= 1'b0;
          state               <= WAIT;
        end
        WAIT: if (bus.mem_resp_valid_i) begin
          if (!pte_v || (!pte_r && pte_w)) begin
            bus.fault_o     <= 1'b1;
            bus.refill_va_o <= va_q;
            state           <= FAULT;
          end else if (pte_r || pte_x) begin
            if (!aligned || !a_ok) begin
              bus.fault_o     <= 1'b1;
              bus.refill_va_o <= va_q;
              state           <= FAULT;
            end else begin
              bus.refill_valid_o <= 1'b1;
              bus.refill_va_o    <= va_q;
              bus.refill_pa_o    <= 64'(PA_BITS'({frac_ppn, 12'h0}));
              bus.refill_perm_o  <= {pte_x, pte_w, pte_r};
              state              <= REFILL;
            end
          end else if (lvl_q == '0) begin
            bus.fault_o     <= 1'b1;
            bus.refill_va_o <= va_q;
            state           <= FAULT;
          end else begin
            lvl_q               <= lvl_q - LW'(1);
            bus.mem_req_valid_o <= 1'b1;
            bus.mem_req_addr_o  <= pte_addr(pte_ppn, va_q, lvl_q - LW'(1));
            state               <= REQ;
          end
        end
        REFILL, FAULT: begin
          bus.miss_ready_o <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_page_table_walker.sv
// Randomized + directed bench for page_table_walker against a walk-level reference model.
module tb_page_table_walker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  page_table_walker_if b();
  page_table_walker dut (.clk(clk), .rst(rst), .bus(b));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  // reference model state
  logic [63:0] pt[3];
  logic [63:0] exp_addr[$];
  logic [63:0] resp_q[$];
  bit          exp_fault;
  logic [63:0] exp_pa;
  logic [2:0]  exp_perm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ptr(input logic [63:0] ppn);
    return (ppn << 10) | 64'h1;
  endfunction

  function automatic logic [63:0] leaf(input logic [63:0] ppn, input logic [63:0] flags);
    return (ppn << 10) | flags;
  endfunction

  // Walk pt[0..2] (levels 2,1,0) with plain arithmetic; fills expected addresses/outcome.
  task automatic plan(input logic [63:0] va, input logic [43:0] satp);
    longint unsigned base, ppn, span, pte;
    exp_addr.delete(); resp_q.delete();
    exp_fault = 1'b1; exp_pa = '0; exp_perm = '0;
    base = 64'(satp);
    for (int lvl = 2; lvl >= 0; lvl--) begin
      pte  = pt[2-lvl];
      ppn  = (pte >> 10) % (64'd1 << 44);
      span = 64'd1 << (9 * lvl);
      exp_addr.push_back(base * 4096 + ((va >> (12 + 9 * lvl)) % 512) * 8);
      resp_q.push_back(pte);
      if (pte[0] == 0 || (pte[1] == 0 && pte[2] == 1)) return;
      if (pte[1] || pte[3]) begin
        if (ppn % span != 0) return;
`ifdef PTW_AD_CHECK_EN
        if (pte[6] == 0) return;
`endif
        exp_fault = 1'b0;
        exp_pa    = (ppn - ppn % span + (va >> 12) % span) * 4096;
        exp_perm  = {pte[3], pte[2], pte[1]};
        return;
      end
      if (lvl == 0) return;
      base = ppn;
    end
  endtask

  function automatic logic [63:0] rnd_pte(input int lvl);
    logic [63:0] p, r;
    logic [43:0] ppn, mask;
    int k;
    p    = {$urandom(), $urandom()};
    r    = {$urandom(), $urandom()};
    ppn  = r[43:0];
    mask = (44'd1 << (9 * lvl)) - 44'd1;
    k    = $urandom_range(0, 9);
    if (k == 0) p[0] = 1'b0;
    else if (k == 1) p[3:0] = {1'($urandom_range(0, 1)), 3'b101};
    else if (k <= 5) begin p[3:0] = 4'b0001; p[53:10] = ppn; end
    else begin
      case ($urandom_range(0, 4))
        0: p[3:1] = 3'b001;
        1: p[3:1] = 3'b011;
        2: p[3:1] = 3'b100;
        3: p[3:1] = 3'b101;
        default: p[3:1] = 3'b111;
      endcase
      p[0] = 1'b1;
      ppn  = ppn & ~mask;
      if (k == 9 && lvl > 0) ppn[0] = 1'b1;
      p[53:10] = ppn;
    end
    return p;
  endfunction

  // Drive one miss, serve PTE reads from resp_q, check against the plan.
  task automatic run_walk(input logic [63:0] va, input logic [43:0] satp, input int stall);
    int cyc_acc, stall_cnt, nreq;
    bit accepted, done, in_req, resp_now, rdy_bad, stable_bad;
    logic [63:0] held;
    nreq = exp_addr.size();
    accepted = 0; done = 0; in_req = 0; resp_now = 0; rdy_bad = 0; stable_bad = 0;
    stall_cnt = 0; cyc_acc = 0; held = '0;
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      @(negedge clk);
      b.mem_resp_valid_i = resp_now;
      if (resp_now) b.mem_resp_data_i = resp_q.size() != 0 ? resp_q.pop_front() : 64'h0;
      resp_now = 0;
      if (!accepted) begin
        b.miss_valid_i = 1'b1; b.miss_va_i = va; b.satp_ppn_i = satp;
        if (b.miss_ready_o) begin accepted = 1; cyc_acc = cyc; end
      end else begin
        // keep a different request pending; the walker must ignore it
        b.miss_va_i = ~va; b.satp_ppn_i = ~satp;
        if (b.miss_ready_o) rdy_bad = 1;
        if (b.refill_valid_o || b.fault_o) begin
          done = 1;
          b.miss_valid_i = 1'b0;
          chk("refill_valid", 64'(b.refill_valid_o), 64'(!exp_fault));
          chk("fault", 64'(b.fault_o), 64'(exp_fault));
          chk("refill_va", b.refill_va_o, va);
          if (!exp_fault) begin
            chk("refill_pa", b.refill_pa_o, exp_pa);
            chk("refill_perm", 64'(b.refill_perm_o), 64'(exp_perm));
          end
          if (stall == 0) chk("latency", 64'(cyc - cyc_acc), 64'(2 * nreq + 1));
        end
        if (b.mem_req_valid_o) begin
          if (!in_req) begin
            in_req = 1; held = b.mem_req_addr_o; stall_cnt = stall;
            chk("req_addr", held, exp_addr.size() != 0 ? exp_addr.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF);
          end else if (b.mem_req_addr_o !== held) stable_bad = 1;
          if (stall_cnt > 0) begin b.mem_req_ready_i = 1'b0; stall_cnt--; end
          else begin b.mem_req_ready_i = 1'b1; in_req = 0; resp_now = 1; end
        end else b.mem_req_ready_i = 1'b0;
      end
    end
    chk("walk_done", 64'(done), 64'd1);
    chk("busy_not_ready", 64'(rdy_bad), 64'd0);
    chk("reqs_left", 64'(exp_addr.size()), 64'd0);
    if (stall > 0) chk("addr_stable", 64'(stable_bad), 64'd0);
    @(negedge clk);
    b.mem_resp_valid_i = 1'b0; b.mem_req_ready_i = 1'b0;
    chk("pulse_width", {62'd0, b.refill_valid_o, b.fault_o}, 64'd0);
    chk("ready_back", 64'(b.miss_ready_o), 64'd1);
  endtask

  initial begin
    logic [63:0] va;
    logic [43:0] satp;
    bit stray;
    b.miss_valid_i = 0; b.miss_va_i = 0; b.satp_ppn_i = 0;
    b.mem_req_ready_i = 0; b.mem_resp_valid_i = 0; b.mem_resp_data_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(b.miss_ready_o), 64'd1);
    chk("rst_req_valid", 64'(b.mem_req_valid_o), 64'd0);
    chk("rst_refill", 64'(b.refill_valid_o), 64'd0);
    chk("rst_fault", 64'(b.fault_o), 64'd0);
    chk("rst_addr", b.mem_req_addr_o, 64'd0);
    chk("rst_pa", b.refill_pa_o, 64'd0);
    rst = 1'b0;

    // 3-level walk, leaf A=0 then A=1
    va = 64'h0000_0040_2030_4567; satp = 44'h80000;
    pt[0] = ptr(64'h80010); pt[1] = ptr(64'h80020); pt[2] = 64'h0000_0000_2000_040F;
    plan(va, satp); run_walk(va, satp, 0);
    pt[2] = 64'h0000_0000_2000_044F;
    plan(va, satp); run_walk(va, satp, 0);
    chk("leaf_pa_const", b.refill_pa_o, 64'h8000_1000);

    // 2 MiB superpage, aligned then misaligned
    va = 64'h0000_0040_0000_0000 | (64'h1A3 << 12) | 64'h567;
    pt[0] = ptr(64'h80010); pt[1] = leaf(64'h80200, 64'h4F); pt[2] = 64'h0;
    plan(va, satp); run_walk(va, satp, 0);
    chk("superpage_pa_const", b.refill_pa_o, 64'h803A_3000);
    pt[1] = leaf(64'h80201, 64'h4F);
    plan(va, satp); run_walk(va, satp, 0);

    // invalid root PTE, W-without-R, level-0 pointer
    pt[0] = 64'h0; plan(va, satp); run_walk(va, satp, 0);
    pt[0] = 64'h5; plan(va, satp); run_walk(va, satp, 0);
    pt[0] = ptr(64'h1234); pt[1] = ptr(64'h5678); pt[2] = ptr(64'h1);
    plan(va, satp); run_walk(va, satp, 0);

    // memory backpressure
    va = 64'h0000_0012_3456_7ABC;
    pt[0] = ptr(64'h80010); pt[1] = ptr(64'h80020); pt[2] = leaf(64'hABCDE, 64'h4B);
    plan(va, satp); run_walk(va, satp, 5);

    // reset while waiting for a PTE, then a stale response
    @(negedge clk);
    b.miss_valid_i = 1'b1; b.miss_va_i = va; b.satp_ppn_i = satp; b.mem_req_ready_i = 1'b1;
    @(negedge clk); b.miss_valid_i = 1'b0;
    @(negedge clk);
    chk("in_wait_req_low", 64'(b.mem_req_valid_o), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; b.mem_req_ready_i = 1'b0;
    b.mem_resp_valid_i = 1'b1; b.mem_resp_data_i = leaf(64'h80001, 64'h4F);
    chk("rst2_ready", 64'(b.miss_ready_o), 64'd1);
    chk("rst2_req_valid", 64'(b.mem_req_valid_o), 64'd0);
    chk("rst2_addr", b.mem_req_addr_o, 64'd0);
    chk("rst2_va", b.refill_va_o, 64'd0);
    chk("rst2_pa", b.refill_pa_o, 64'd0);
    chk("rst2_perm", 64'(b.refill_perm_o), 64'd0);
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b.mem_resp_valid_i = 1'b0;
      if (b.refill_valid_o || b.fault_o || b.mem_req_valid_o) stray = 1;
    end
    chk("stale_resp_ignored", 64'(stray), 64'd0);
    plan(va, satp); run_walk(va, satp, 0);

    // randomized walks
    for (int t = 0; t < 60; t++) begin
      va   = {$urandom(), $urandom()};
      satp = 44'({$urandom(), $urandom()});
      for (int i = 0; i < 3; i++) pt[i] = rnd_pte(2 - i);
      plan(va, satp);
      run_walk(va, satp, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
